// File: rtl/regfile_pkg.sv
// Shared widths, default sizes and word types for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  typedef logic [XLEN_DEF-1:0]            word_t;
  typedef logic [addr_w(NREGS_DEF)-1:0]   addr_t;

endpackage

// File: rtl/rf_entry.sv
// One architectural register: data word plus its scoreboard busy bit.
module rf_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  input  logic            set_busy,
  input  logic            clr_busy,
  input  logic            flush,
  output logic [XLEN-1:0] q,
  output logic            busy
);

  // A newly allocated producer is younger than any retiring one, so set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (we)
        q <= wd;
      if (flush)
        busy <= 1'b0;
      else if (set_busy)
        busy <= 1'b1;
      else if (clr_busy)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with busy scoreboard and optional write->read bypass.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  ent_q  [NREGS];
  logic [XLEN-1:0]  ent_wd [NREGS];
  logic [NREGS-1:0] ent_we;
  logic [NREGS-1:0] busy_q;

  // Write-port decode: ascending scan so the highest enabled port wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      ent_we[r] = 1'b0;
      ent_wd[r] = '0;
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) begin
          ent_we[r] = 1'b1;
          ent_wd[r] = wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_ent
    if (ZERO_REG != 0 && r == 0) begin : g_zero
      assign ent_q[r]  = '0;
      assign busy_q[r] = 1'b0;
    end else begin : g_reg
      rf_entry #(.XLEN(XLEN)) u_entry (
        .clk      (clk),
        .rst      (rst),
        .we       (ent_we[r]),
        .wd       (ent_wd[r]),
        .set_busy (alloc_en && alloc_addr == AW'(r)),
        .clr_busy (ent_we[r]),
        .flush    (flush),
        .q        (ent_q[r]),
        .busy     (busy_q[r])
      );
    end
  end

  // Read muxes; a forwarded write clears busy unless the same register is re-allocated.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;
    rs_data = '0;
    rs_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = rs_addr[p*AW +: AW];
      rd = ent_q[ra];
      rb = busy_q[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && wr_addr[w*AW +: AW] == ra) begin
            rd = wr_data[w*XLEN +: XLEN];
            if (!(alloc_en && alloc_addr == ra))
              rb = 1'b0;
          end
        end
      end
      if (ZERO_REG != 0 && ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
      rs_data[p*XLEN +: XLEN] = rd;
      rs_busy[p]              = rb;
    end
  end

  assign busy_vec = busy_q;

endmodule
